// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receiver states, default bit timing and frame constants.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/limit_counter.sv
// Library up-counter that wraps to zero on reaching a programmable limit.
module limit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == limit) ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sipo_reg.sv
// Library serial-in parallel-out shift register; new bits enter at the LSB.
module sipo_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 2) begin : g_width_check
        $error("sipo_reg: WIDTH must be at least 2");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/serial_rx.sv
// Framed serial receiver (start, MSB-first data, stop) with a valid/ready holding register.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module serial_rx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  parity_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] HALF_LIMIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LIMIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_WIDTH - 1);

    if (CLKS_PER_BIT < 4) begin : g_clks_check
        $error("serial_rx: CLKS_PER_BIT must be at least 4");
    end

    rx_state_t             state_q, state_d;
    logic                  rx_meta, rx_s;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_limit_c;
    logic                  cnt_clear_c;
    logic                  tick_c;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  shift_en_c;
    logic                  commit_c;
    logic                  frame_err_c;
    logic                  par_en_c;
    logic [DATA_WIDTH-1:0] shift_q;

    // Two-flop synchroniser; idle line level is high.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign cnt_clear_c = (state_q == IDLE) || (state_q == BREAK);
    assign cnt_limit_c = (state_q == START) ? HALF_LIMIT : FULL_LIMIT;
    assign tick_c      = !cnt_clear_c && (cnt == cnt_limit_c);

    limit_counter #(.WIDTH(CW)) u_bit_timer (
        .clk   (clk),
        .rst_n (clr_n),
        .clear (cnt_clear_c),
        .en    (1'b1),
        .limit (cnt_limit_c),
        .count (cnt)
    );

    sipo_reg #(.WIDTH(DATA_WIDTH)) u_shift (
        .clk   (clk),
        .rst_n (clr_n),
        .en    (shift_en_c),
        .din   (rx_s),
        .q     (shift_q)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_en_c  = 1'b0;
        par_en_c    = 1'b0;
        commit_c    = 1'b0;
        frame_err_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_s == START_BIT) state_d = START;
            end
            START: begin
                idx_d = '0;
                if (tick_c) state_d = (rx_s == START_BIT) ? DATA : IDLE;
            end
            DATA: begin
                if (tick_c) begin
                    shift_en_c = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick_c) begin
                    par_en_c = 1'b1;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (tick_c) begin
                    if (rx_s == STOP_BIT) begin
                        commit_c = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s == STOP_BIT) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SERIAL_RX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            par_q <= 1'b0;
        end else if (par_en_c) begin
            par_q <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            parity_err <= 1'b0;
        end else if (commit_c && (!data_valid || data_ready)) begin
            parity_err <= ^{shift_q, par_q};
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Holding register: a commit into a full, unacknowledged register is dropped as overrun.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= frame_err_c;
            if (commit_c && (!data_valid || data_ready)) begin
                data_out   <= shift_q;
                data_valid <= 1'b1;
            end else if (commit_c) begin
                overrun <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx at 16 clocks per bit, 8 data bits.
module tb_serial_rx;

    localparam int unsigned DW  = 8;
    localparam int unsigned CPB = 16;

    logic          clk;
    logic          clr_n;
    logic          rx;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;

    int            checks;
    int            errors;
    int            dv_cycles;
    int            fe_cnt;
    bit            ov_seen;
    bit            pe_seen;
    logic [DW-1:0] last_data;
    logic          last_pe;

    serial_rx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (clr_n) begin
            if (data_valid) begin
                dv_cycles = dv_cycles + 1;
                last_data = data_out;
                last_pe   = parity_err;
            end
            if (frame_err) fe_cnt = fe_cnt + 1;
            if (overrun) ov_seen = 1'b1;
            if (parity_err) pe_seen = 1'b1;
        end
    end

    task automatic clear_mon();
        dv_cycles = 0;
        fe_cnt    = 0;
        ov_seen   = 1'b0;
        pe_seen   = 1'b0;
        last_data = '0;
        last_pe   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = DW - 1; i >= 0; i--) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

    function automatic logic even_par(input logic [DW-1:0] d);
        return ^d;
    endfunction

    task automatic expect_word(input string name, input logic [DW-1:0] exp);
        checks++;
        if (last_data !== exp) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, last_data, exp);
        end
        checks++;
        if (dv_cycles != 1) begin
            errors++;
            $display("FAIL %s valid_cycles: got %0d expected 1", name, dv_cycles);
        end
        checks++;
        if (fe_cnt != 0 || ov_seen) begin
            errors++;
            $display("FAIL %s flags: frame_err pulses %0d overrun %0b expected 0 0", name, fe_cnt, ov_seen);
        end
    endtask

    task automatic test_reset();
        clr_n      = 1'b0;
        rx         = 1'b1;
        data_ready = 1'b1;
        clear_mon();
        idle(3);
        checks++;
        if ({data_out, data_valid, frame_err, overrun, parity_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b/%b expected all 0",
                     data_out, data_valid, frame_err, overrun, parity_err);
        end
        clr_n = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        clear_mon();
        send_frame(8'hA5, 1'b1, even_par(8'hA5));
        idle(20);
        expect_word("frame_a5", 8'hA5);
        checks++;
        if (pe_seen) begin
            errors++;
            $display("FAIL frame_a5 parity_err: got 1 expected 0");
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        checks++;
        if (dv_cycles != 0 || fe_cnt != 0) begin
            errors++;
            $display("FAIL glitch: valid cycles %0d frame_err %0d expected 0 0", dv_cycles, fe_cnt);
        end
        clear_mon();
        send_frame(8'h3C, 1'b1, even_par(8'h3C));
        idle(20);
        expect_word("after_glitch_3c", 8'h3C);
    endtask

    task automatic test_break();
        clear_mon();
        send_frame(8'hFF, 1'b0, even_par(8'hFF));
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(20);
        checks++;
        if (fe_cnt != 1) begin
            errors++;
            $display("FAIL break_frame_err: got %0d pulses expected 1", fe_cnt);
        end
        checks++;
        if (dv_cycles != 0) begin
            errors++;
            $display("FAIL break_valid: got %0d cycles expected 0", dv_cycles);
        end
        clear_mon();
        send_frame(8'h01, 1'b1, even_par(8'h01));
        idle(20);
        expect_word("after_break_01", 8'h01);
    endtask

    task automatic test_overrun();
        clear_mon();
        data_ready = 1'b0;
        send_frame(8'h11, 1'b1, even_par(8'h11));
        idle(10);
        send_frame(8'h22, 1'b1, even_par(8'h22));
        idle(20);
        checks++;
        if (data_out !== 8'h11 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_hold: got %h valid %b expected 11 valid 1", data_out, data_valid);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        checks++;
        if (data_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_handshake: valid %b overrun %b expected 0 0", data_valid, overrun);
        end
        idle(3);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("FAIL ready_low_idle: valid %b expected 0", data_valid);
        end
        data_ready = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] d;
        d = 8'hC3;
        send_bit(1'b0);
        for (int i = DW - 1; i >= DW - 3; i--) send_bit(d[i]);
        rx = d[DW-4];
        idle(CPB / 2);
        clr_n = 1'b0;
        idle(3);
        checks++;
        if ({data_out, data_valid, frame_err, overrun, parity_err} !== '0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got %h/%b/%b/%b/%b expected all 0",
                     data_out, data_valid, frame_err, overrun, parity_err);
        end
        rx = 1'b1;
        idle(2);
        clr_n = 1'b1;
        idle(5);
        clear_mon();
        send_frame(8'h5A, 1'b1, even_par(8'h5A));
        idle(20);
        expect_word("after_reset_5a", 8'h5A);
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        checks++;
        if (last_data !== 8'h07 || last_pe !== 1'b0) begin
            errors++;
            $display("FAIL parity_good: data %h perr %b expected 07 0", last_data, last_pe);
        end
        clear_mon();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        checks++;
        if (last_data !== 8'h07 || last_pe !== 1'b1 || dv_cycles != 1) begin
            errors++;
            $display("FAIL parity_bad: data %h perr %b valid %0d expected 07 1 1",
                     last_data, last_pe, dv_cycles);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
